// File: rtl/arith_pkg.sv
// Shared arithmetic types: FSM states and counter sizing.
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  function automatic int cnt_width(input int ndig);
    return $clog2(ndig) + 1;
  endfunction

endpackage

// File: rtl/borrow_slice.sv
// DIGIT-wide combinational ripple-borrow slice.
module borrow_slice #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             c_in,
  output logic [DIGIT-1:0] diff,
  output logic             b_out,
  output logic             b_msb_in
);

  logic br;

  // Ripple the borrow LSB to MSB; remember the borrow entering the top bit.
  always_comb begin
    br       = c_in;
    diff     = '0;
    b_msb_in = c_in;
    for (int i = 0; i < DIGIT; i++) begin
      diff[i] = a[i] ^ b[i] ^ br;
      if (i == DIGIT - 1) b_msb_in = br;
      br = (~a[i] & b[i]) | (~a[i] & br) | (b[i] & br);
    end
    b_out = br;
  end

endmodule

// File: rtl/digit_serial_subtractor.sv
// Multi-cycle D = X - Y - BIN, DIGIT bits per clock.
module digit_serial_subtractor
  import arith_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d,
  output logic             bout,
  output logic             zero,
  output logic             ovf
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = cnt_width(NDIG);

  state_t           state;
  state_t           state_nx;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] xr;
  logic [WIDTH-1:0] yr;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] res_nx;
  logic             brw;
  logic [31:0]      base;
  logic             last;
  logic [DIGIT-1:0] sa;
  logic [DIGIT-1:0] sb;
  logic [DIGIT-1:0] sdiff;
  logic             sbout;
  logic             sbmsb;

  assign base = 32'(cnt) * 32'(DIGIT);
  assign last = (cnt == CW'(NDIG - 1));
  assign sa   = xr[base +: DIGIT];
  assign sb   = yr[base +: DIGIT];

  borrow_slice #(
    .DIGIT(DIGIT)
  ) u_slice (
    .a       (sa),
    .b       (sb),
    .c_in    (brw),
    .diff    (sdiff),
    .b_out   (sbout),
    .b_msb_in(sbmsb)
  );

  // Result register with the current digit merged in.
  always_comb begin
    res_nx = res;
    res_nx[base +: DIGIT] = sdiff;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = RUN;
      end
      RUN: begin
        if (last) state_nx = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Operand latch, digit iteration and result/flag capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt  <= '0;
      xr   <= '0;
      yr   <= '0;
      res  <= '0;
      brw  <= 1'b0;
      d    <= '0;
      bout <= 1'b0;
      zero <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            xr  <= x;
            yr  <= y;
            brw <= bin;
            cnt <= '0;
          end
        end
        RUN: begin
          res <= res_nx;
          brw <= sbout;
          cnt <= cnt + CW'(1);
          if (last) begin
            d    <= res_nx;
            bout <= sbout;
            zero <= ~|res_nx;
            ovf  <= sbmsb ^ sbout;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_digit_serial_subtractor.sv
// Directed + randomised checks over several WIDTH/DIGIT configs.
module tb_digit_serial_subtractor;

  localparam int N = 7;
  localparam int WS[N] = '{8, 8, 8, 8, 16, 16, 16};
  localparam int DS[N] = '{1, 2, 4, 8, 1, 4, 16};

  logic         clk = 1'b0;
  logic [N-1:0] rst;
  logic [N-1:0] in_valid;
  logic [N-1:0] in_ready;
  logic [N-1:0] bin;
  logic [N-1:0] out_valid;
  logic [N-1:0] out_ready;
  logic [N-1:0] bout;
  logic [N-1:0] zero;
  logic [N-1:0] ovf;
  logic [15:0]  x[N];
  logic [15:0]  y[N];
  logic [15:0]  d_w[N];

  int n_pass = 0;
  int n_tot  = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    digit_serial_subtractor #(
      .WIDTH(WS[g]),
      .DIGIT(DS[g])
    ) u_dut (
      .clk      (clk),
      .reset    (rst[g]),
      .in_valid (in_valid[g]),
      .in_ready (in_ready[g]),
      .x        (x[g][WS[g]-1:0]),
      .y        (y[g][WS[g]-1:0]),
      .bin      (bin[g]),
      .out_valid(out_valid[g]),
      .out_ready(out_ready[g]),
      .d        (d_w[g][WS[g]-1:0]),
      .bout     (bout[g]),
      .zero     (zero[g]),
      .ovf      (ovf[g])
    );
    if (WS[g] < 16) begin : g_pad
      assign d_w[g][15:WS[g]] = '0;
    end
  end

  typedef struct {
    int          inst;
    logic [15:0] xv;
    logic [15:0] yv;
    logic        bv;
    logic [15:0] ed;
    logic        eb;
    logic        ez;
    logic        eo;
  } vec_t;

  vec_t tv[10];

  task automatic chk(input string nm, input int i,
                     input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s inst%0d: got %0h want %0h", nm, i, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int i, input logic [15:0] xv,
                     input logic [15:0] yv, input logic bv,
                     input logic [15:0] ed, input logic eb,
                     input logic ez, input logic eo);
    int n;
    x[i] = xv;
    y[i] = yv;
    bin[i] = bv;
    in_valid[i] = 1'b1;
    chk("in_ready_idle", i, 32'(in_ready[i]), 1);
    tick();
    in_valid[i] = 1'b0;
    x[i] = ~xv;
    y[i] = ~yv;
    bin[i] = ~bv;
    n = 0;
    while (!out_valid[i] && n < 100) begin
      tick();
      n++;
    end
    chk("latency", i, 32'(n), 32'(WS[i] / DS[i]));
    chk("d", i, 32'(d_w[i]), 32'(ed));
    chk("bout", i, 32'(bout[i]), 32'(eb));
    chk("zero", i, 32'(zero[i]), 32'(ez));
    chk("ovf", i, 32'(ovf[i]), 32'(eo));
    out_ready[i] = 1'b1;
    tick();
    out_ready[i] = 1'b0;
    chk("out_valid_drop", i, 32'(out_valid[i]), 0);
  endtask

  task automatic rnd(input int i);
    int          w;
    int          sx;
    int          sy;
    int          r;
    logic [16:0] full;
    logic [15:0] m;
    logic [15:0] xv;
    logic [15:0] yv;
    logic        bv;
    logic        eo;
    w  = WS[i];
    m  = (w == 16) ? 16'hFFFF : 16'h00FF;
    xv = 16'($urandom) & m;
    yv = 16'($urandom) & m;
    bv = 1'($urandom);
    full = {1'b0, xv} - {1'b0, yv} - 17'(bv);
    sx = (w == 16) ? int'($signed(xv)) : int'($signed(xv[7:0]));
    sy = (w == 16) ? int'($signed(yv)) : int'($signed(yv[7:0]));
    r  = sx - sy - int'(bv);
    eo = (r < -(1 << (w - 1))) || (r > (1 << (w - 1)) - 1);
    run(i, xv, yv, bv, full[15:0] & m,
        (w == 16) ? full[16] : full[8],
        ((full[15:0] & m) == 16'h0), eo);
  endtask

  initial begin
    tv[0] = '{0, 16'h05, 16'h03, 1'b0, 16'h02, 1'b0, 1'b0, 1'b0};
    tv[1] = '{2, 16'h00, 16'h01, 1'b0, 16'hFF, 1'b1, 1'b0, 1'b0};
    tv[2] = '{2, 16'h01, 16'h01, 1'b1, 16'hFF, 1'b1, 1'b0, 1'b0};
    tv[3] = '{1, 16'h80, 16'h01, 1'b0, 16'h7F, 1'b0, 1'b0, 1'b1};
    tv[4] = '{1, 16'h7F, 16'hFF, 1'b0, 16'h80, 1'b1, 1'b0, 1'b1};
    tv[5] = '{1, 16'h10, 16'h10, 1'b0, 16'h00, 1'b0, 1'b1, 1'b0};
    tv[6] = '{3, 16'h05, 16'h05, 1'b1, 16'hFF, 1'b1, 1'b0, 1'b0};
    tv[7] = '{5, 16'h1234, 16'h0235, 1'b0, 16'h0FFF, 1'b0, 1'b0, 1'b0};
    tv[8] = '{6, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b0, 1'b1};
    tv[9] = '{4, 16'h0000, 16'hFFFF, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0};

    rst       = '1;
    in_valid  = '0;
    out_ready = '0;
    bin       = '0;
    for (int i = 0; i < N; i++) begin
      x[i] = '0;
      y[i] = '0;
    end
    tick();
    tick();
    rst = '0;

    for (int i = 0; i < N; i++) begin
      chk("rst_in_ready", i, 32'(in_ready[i]), 1);
      chk("rst_out_valid", i, 32'(out_valid[i]), 0);
      chk("rst_d", i, 32'(d_w[i]), 0);
      chk("rst_flags", i, {29'b0, bout[i], zero[i], ovf[i]}, 0);
    end

    for (int k = 0; k < 10; k++)
      run(tv[k].inst, tv[k].xv, tv[k].yv, tv[k].bv,
          tv[k].ed, tv[k].eb, tv[k].ez, tv[k].eo);

    // Backpressure on the 8/2 instance.
    begin
      int n;
      x[1] = 16'h80;
      y[1] = 16'h01;
      bin[1] = 1'b0;
      in_valid[1] = 1'b1;
      tick();
      in_valid[1] = 1'b0;
      n = 0;
      while (!out_valid[1] && n < 100) begin
        tick();
        n++;
      end
      chk("bp_latency", 1, 32'(n), 4);
      x[1] = 16'h33;
      y[1] = 16'h11;
      in_valid[1] = 1'b1;
      for (int c = 0; c < 5; c++) begin
        tick();
        chk("bp_out_valid", 1, 32'(out_valid[1]), 1);
        chk("bp_in_ready", 1, 32'(in_ready[1]), 0);
        chk("bp_d", 1, 32'(d_w[1]), 32'h7F);
        chk("bp_flags", 1, {29'b0, bout[1], zero[1], ovf[1]}, 1);
      end
      in_valid[1] = 1'b0;
      out_ready[1] = 1'b1;
      tick();
      out_ready[1] = 1'b0;
      chk("bp_idle_ready", 1, 32'(in_ready[1]), 1);
      chk("bp_idle_valid", 1, 32'(out_valid[1]), 0);
      chk("bp_idle_d", 1, 32'(d_w[1]), 32'h7F);
    end

    // Reset in the middle of a run on the 8/1 instance.
    x[0] = 16'hC3;
    y[0] = 16'h11;
    bin[0] = 1'b0;
    in_valid[0] = 1'b1;
    tick();
    in_valid[0] = 1'b0;
    tick();
    tick();
    tick();
    chk("mid_busy", 0, 32'(in_ready[0]), 0);
    rst[0] = 1'b1;
    tick();
    rst[0] = 1'b0;
    chk("mid_in_ready", 0, 32'(in_ready[0]), 1);
    chk("mid_out_valid", 0, 32'(out_valid[0]), 0);
    chk("mid_d", 0, 32'(d_w[0]), 0);
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("mid_no_result", 0, 32'(out_valid[0]), 0);
    end
    run(0, 16'h0A, 16'h04, 1'b0, 16'h06, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < N; i++)
      for (int r = 0; r < 6; r++)
        rnd(i);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/digit_serial_subtractor.md
Name: digit_serial_subtractor

Overview:
Parametrised multi-cycle subtractor that computes D = X - Y - BIN over WIDTH-bit operands. It processes DIGIT bits per clock through one shared DIGIT-wide ripple-borrow slice, trading latency for area compared with a full-width combinational ripple-borrow subtractor. It sits in the arithmetic datapath between operand producers and result consumers, with valid/ready handshakes on both sides. It also reports zero and signed-overflow flags.

Parameters:
WIDTH, 8, operand/result width in bits; must be a multiple of DIGIT, WIDTH >= 2.
DIGIT, 1, bits processed per cycle; 1 <= DIGIT <= WIDTH.
(derived) NDIG = WIDTH/DIGIT, number of digit cycles; CW = clog2(NDIG)+1, counter width.

Ports:
clk  input  1  single clock, rising edge.
reset  input  1  synchronous, active-high reset.
in_valid  input  1  operand set valid.
in_ready  output  1  block can accept operands.
x  input  WIDTH  minuend.
y  input  WIDTH  subtrahend.
bin  input  1  borrow-in.
out_valid  output  1  result valid.
out_ready  input  1  consumer accepts result.
d  output  WIDTH  difference, modulo 2^WIDTH.
bout  output  1  borrow-out; 1 iff x < y + bin, unsigned.
zero  output  1  d == 0.
ovf  output  1  signed (two's complement) overflow of x - y - bin.

Behaviour:
- Reset is synchronous, active-high, and wins over all other inputs. On reset: state=IDLE, in_ready=1, out_valid=0, d=0, bout=0, zero=0, ovf=0, internal counter=0, borrow register=0.
- Reset mid-RUN or in DONE abandons the operation; no result is produced.
- FSM states and transitions:
  - IDLE: in_ready=1. If in_valid is high at the edge, latch x, y, bin into the operand registers, set the borrow register to bin, set the counter to 0, and go to RUN.
  - RUN: in_ready=0, out_valid=0. Each edge:
    - the slice computes digit cnt (bits [cnt*DIGIT +: DIGIT]) using the borrow register;
    - the DIGIT result bits are written into the result register;
    - the borrow register takes the slice borrow-out;
    - cnt increments.
    - At the edge where cnt == NDIG-1, go to DONE.
  - DONE: out_valid=1 and d/bout/zero/ovf are stable. Hold while out_ready=0. On the edge where out_ready=1, go to IDLE and drop out_valid.
- Latency: accept at edge k gives out_valid=1 after edge k+NDIG. Throughput is one result per NDIG+2 cycles; there is no overlap of accept and output.
- in_ready is asserted only in IDLE. in_valid in other states is ignored, and x, y, bin may change freely after accept.
- Slice per bit: diff = a ^ b ^ c; borrow = (~a & b) | (~a & c) | (b & c).
- bout = final borrow register value.
- ovf = borrow into the MSB XOR borrow out of the MSB. With DIGIT > 1, the slice exposes its internal borrow into its top bit; this value is used on the last digit.
- zero is computed from the complete result register when entering DONE.
- Flags and d are registered outputs and update only on the transition into DONE.
- Edge cases:
  - DIGIT == WIDTH: NDIG = 1, a single RUN cycle.
  - x == y with bin=1 gives d all-ones, bout=1, ovf=0.

Decomposition:
- Shared package (arith_pkg) holds the FSM state enum (IDLE, RUN, DONE) and a function or constant for the clog2 counter width.
- One natural sub-module: borrow_slice (parameter DIGIT), a combinational ripple-borrow chain with inputs a[DIGIT], b[DIGIT], c_in. Outputs are diff[DIGIT], b_out, and b_msb_in (the borrow into the top bit).
- The top level holds the FSM, counter, operand/result registers, and flag logic.

Test Plan:
- WIDTH=8, DIGIT=1; x=0x05, y=0x03, bin=0 -> after 8 cycles: d=0x02, bout=0, zero=0, ovf=0.
- WIDTH=8, DIGIT=4; x=0x00, y=0x01, bin=0 -> after 2 cycles: d=0xFF, bout=1, ovf=0. Then x=0x01, y=0x01, bin=1 -> d=0xFF, bout=1.
- WIDTH=8, DIGIT=2; x=0x80, y=0x01 -> d=0x7F, bout=0, ovf=1. Then x=0x7F, y=0xFF -> d=0x80, bout=1, ovf=1. Then x=0x10, y=0x10 -> d=0x00, zero=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid stays 1, d/flags unchanged, in_ready=0, and a new in_valid is ignored. out_ready=1 -> IDLE next cycle.
- Reset mid-RUN (cycle 3 of 8) -> next cycle IDLE, in_ready=1, out_valid=0, d=0. A fresh 0x0A-0x04 then gives d=0x06.
- Randomised sweep over WIDTH in {8, 16} and DIGIT in {1, 2, 4, WIDTH}, compared against a reference model x-y-bin -> all fields match, and latency equals NDIG every time.
